// File: rtl/store_buffer_ctrl.sv
// rtl/store_buffer_ctrl.sv - store buffer: lane-aligned FIFO of pending stores drained to data memory
// Loads hitting a buffered word stall until the matching store has drained.

module store_buffer_ctrl #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       st_valid,
   output logic                       st_ready,
   input  logic [31:0]                st_addr,
   input  logic [31:0]                st_data,
   input  logic [2:0]                 st_funct3,
   input  logic                       ld_valid,
   input  logic [31:0]                ld_addr,
   output logic                       ld_stall,
   output logic                       mem_req,
   output logic [31:0]                mem_addr,
   output logic [31:0]                mem_wdata,
   output logic [3:0]                 mem_be,
   input  logic                       mem_ack,
   output logic                       store_err,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {IDLE, REQ} state_t;

   state_t            state, state_next;
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [DEPTH-1:0]  valid;
   logic [29:0]       e_addr  [DEPTH];
   logic [31:0]       e_wdata [DEPTH];
   logic [3:0]        e_be    [DEPTH];

   logic              legal, push, pop, hit;
   logic [3:0]        be_in;
   logic [31:0]       wdata_in;
   logic              unused_ok;

   assign unused_ok = &{1'b0, ld_addr[1:0]};

   assign st_ready = (count < CW'(DEPTH));

   always_comb begin
      legal    = 1'b0;
      be_in    = 4'b0000;
      wdata_in = 32'h0;
      case (st_funct3)
         3'b000: begin
            legal    = 1'b1;
            be_in    = 4'b0001 << st_addr[1:0];
            wdata_in = {24'h0, st_data[7:0]} << {st_addr[1:0], 3'b000};
         end
         3'b001: begin
            legal    = ~st_addr[0];
            be_in    = st_addr[1] ? 4'b1100 : 4'b0011;
            wdata_in = st_addr[1] ? {st_data[15:0], 16'h0} : {16'h0, st_data[15:0]};
         end
         3'b010: begin
            legal    = (st_addr[1:0] == 2'b00);
            be_in    = 4'b1111;
            wdata_in = st_data;
         end
         default: ;
      endcase
   end

   assign push = st_valid && st_ready && legal;
   assign pop  = (state == REQ) && mem_ack;

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (count != '0 || push) state_next = REQ;
         REQ:  if (pop && !push && count == CW'(1)) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         valid     <= '0;
         store_err <= 1'b0;
      end else begin
         state     <= state_next;
         store_err <= st_valid && st_ready && !legal;
         if (push) begin
            wr_ptr        <= wr_ptr + 1'b1;
            valid[wr_ptr] <= 1'b1;
         end
         if (pop) begin
            rd_ptr        <= rd_ptr + 1'b1;
            valid[rd_ptr] <= 1'b0;
         end
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   // Payload storage carries no reset; the valid bits qualify it.
   always_ff @(posedge clk) begin
      if (push) begin
         e_addr[wr_ptr]  <= st_addr[31:2];
         e_wdata[wr_ptr] <= wdata_in;
         e_be[wr_ptr]    <= be_in;
      end
   end

   assign mem_req   = (state == REQ);
   assign mem_addr  = mem_req ? {e_addr[rd_ptr], 2'b00} : 32'h0;
   assign mem_wdata = mem_req ? e_wdata[rd_ptr] : 32'h0;
   assign mem_be    = mem_req ? e_be[rd_ptr] : 4'b0000;

   always_comb begin
      hit = push && (st_addr[31:2] == ld_addr[31:2]);
      for (int i = 0; i < DEPTH; i++) begin
         if (valid[i] && e_addr[i] == ld_addr[31:2]) hit = 1'b1;
      end
   end

   assign ld_stall = !reset && ld_valid && hit;

endmodule

// File: tb/tb_store_buffer_ctrl.sv
// tb/tb_store_buffer_ctrl.sv - directed self-checking bench for store_buffer_ctrl
// Inputs change and outputs are sampled on the falling clock edge.

module tb_store_buffer_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        st_valid;
   logic        st_ready;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic [2:0]  st_funct3;
   logic        ld_valid;
   logic [31:0] ld_addr;
   logic        ld_stall;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic        store_err;
   logic [2:0]  count;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   store_buffer_ctrl #(.DEPTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .st_valid  (st_valid),
      .st_ready  (st_ready),
      .st_addr   (st_addr),
      .st_data   (st_data),
      .st_funct3 (st_funct3),
      .ld_valid  (ld_valid),
      .ld_addr   (ld_addr),
      .ld_stall  (ld_stall),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .mem_ack   (mem_ack),
      .store_err (store_err),
      .count     (count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
      st_valid  = 1'b1;
      st_addr   = a;
      st_data   = d;
      st_funct3 = f;
   endtask

   initial begin
      reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_funct3 = '0;
      ld_valid = 1'b0; ld_addr = '0; mem_ack = 1'b0;

      // reset state, with a matching load and store presented
      drive_st(32'h40, 32'h1, 3'b010);
      ld_valid = 1'b1; ld_addr = 32'h40;
      step();
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_store_err", 32'(store_err), 32'd0);
      check("rst_ld_stall", 32'(ld_stall), 32'd0);
      check("rst_mem_be", 32'(mem_be), 32'd0);
      st_valid = 1'b0; ld_valid = 1'b0;
      step();
      reset = 1'b0;
      step();

      // SB to lane 3, ack tied high
      mem_ack = 1'b1;
      drive_st(32'h3, 32'hAB, 3'b000);
      step();
      st_valid = 1'b0;
      check("sb_mem_req", 32'(mem_req), 32'd1);
      check("sb_mem_addr", mem_addr, 32'h0);
      check("sb_mem_be", 32'(mem_be), 32'h8);
      check("sb_mem_wdata", mem_wdata, 32'hAB00_0000);
      check("sb_count_1", 32'(count), 32'd1);
      step();
      check("sb_count_0", 32'(count), 32'd0);
      check("sb_req_off", 32'(mem_req), 32'd0);

      // SH then SW back to back, ack delayed
      mem_ack = 1'b0;
      drive_st(32'h102, 32'hBEEF, 3'b001);
      step();
      drive_st(32'h104, 32'h1234_5678, 3'b010);
      step();
      st_valid = 1'b0;
      check("shsw_count", 32'(count), 32'd2);
      step();
      check("shsw_hold_addr", mem_addr, 32'h100);
      check("shsw_hold_be", 32'(mem_be), 32'hC);
      check("shsw_hold_wdata", mem_wdata, 32'hBEEF_0000);
      mem_ack = 1'b1;
      step();
      check("shsw_2nd_req", 32'(mem_req), 32'd1);
      check("shsw_2nd_addr", mem_addr, 32'h104);
      check("shsw_2nd_be", 32'(mem_be), 32'hF);
      check("shsw_2nd_wdata", mem_wdata, 32'h1234_5678);
      step();
      check("shsw_empty", 32'(count), 32'd0);
      check("shsw_idle", 32'(mem_req), 32'd0);
      mem_ack = 1'b0;

      // illegal stores
      drive_st(32'h1, 32'h55, 3'b001);
      step();
      check("err_mis_pulse", 32'(store_err), 32'd1);
      check("err_mis_count", 32'(count), 32'd0);
      drive_st(32'h0, 32'h55, 3'b011);
      step();
      st_valid = 1'b0;
      check("err_f3_pulse", 32'(store_err), 32'd1);
      check("err_f3_count", 32'(count), 32'd0);
      step();
      check("err_clear", 32'(store_err), 32'd0);
      check("err_no_req", 32'(mem_req), 32'd0);

      // fill to DEPTH, fifth held off
      for (int i = 0; i < 4; i++) begin
         drive_st(32'h10 + 32'(4 * i), 32'hA0 + 32'(i), 3'b010);
         step();
      end
      check("full_count", 32'(count), 32'd4);
      check("full_ready", 32'(st_ready), 32'd0);
      drive_st(32'h20, 32'hA4, 3'b010);
      step();
      check("full_held", 32'(count), 32'd4);
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      check("full_pop_count", 32'(count), 32'd3);
      check("full_pop_ready", 32'(st_ready), 32'd1);
      step();
      st_valid = 1'b0;
      check("full_refill", 32'(count), 32'd4);
      mem_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("fifo_order_addr", mem_addr, 32'h14 + 32'(4 * i));
         check("fifo_order_data", mem_wdata, 32'hA1 + 32'(i));
         step();
      end
      check("full_drained", 32'(count), 32'd0);

      // simultaneous push and pop
      drive_st(32'h30, 32'h30, 3'b010);
      step();
      drive_st(32'h34, 32'h34, 3'b010);
      step();
      st_valid = 1'b0;
      check("pushpop_count", 32'(count), 32'd1);
      check("pushpop_addr", mem_addr, 32'h34);
      step();
      check("pushpop_empty", 32'(count), 32'd0);
      mem_ack = 1'b0;

      // load hazard
      drive_st(32'h200, 32'hCAFE, 3'b010);
      step();
      st_valid = 1'b0;
      ld_valid = 1'b1; ld_addr = 32'h203;
      #1 check("ld_hit", 32'(ld_stall), 32'd1);
      ld_addr = 32'h204;
      #1 check("ld_miss", 32'(ld_stall), 32'd0);
      ld_addr = 32'h203;
      mem_ack = 1'b1;
      step();
      check("ld_after_ack", 32'(ld_stall), 32'd0);
      drive_st(32'h300, 32'h1, 3'b010);
      ld_addr = 32'h301;
      #1 check("ld_hit_incoming", 32'(ld_stall), 32'd1);
      step();
      st_valid = 1'b0;
      step();
      ld_valid = 1'b0;
      mem_ack = 1'b0;
      check("ld_drained", 32'(count), 32'd0);

      // reset mid-transaction
      for (int i = 0; i < 3; i++) begin
         drive_st(32'h400 + 32'(4 * i), 32'h9, 3'b010);
         step();
      end
      st_valid = 1'b0;
      check("mid_count", 32'(count), 32'd3);
      check("mid_req", 32'(mem_req), 32'd1);
      reset = 1'b1;
      #1;
      check("mid_rst_req", 32'(mem_req), 32'd0);
      check("mid_rst_count", 32'(count), 32'd0);
      check("mid_rst_addr", mem_addr, 32'h0);
      step();
      reset = 1'b0;
      step();
      step();
      check("post_rst_req", 32'(mem_req), 32'd0);
      check("post_rst_count", 32'(count), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
